dac_sample_feeder: RTL
======================

Name: dac_sample_feeder

Overview:
Elastic sample buffer that sits directly upstream of the second-order sigma-delta DAC.
- Accepts 16-bit signed PCM samples from the speech filter engine over a valid/ready push interface.
- Presents one sample at a time to the DAC's pull interface; the DAC pulses an ack once per 256 clocks.
- Absorbs the burstiness of the filter engine and handles underrun deterministically.
- Reports fill level and underrun statistics for debug.

Parameters:
- DEPTH, 8: FIFO depth in samples; power of two, 2..64.
- WIDTH, 16: sample width, signed two's complement.
- CNT_W, 8: width of the saturating underrun counter.

Ports:
- clk  in  1  system clock (2.5 MHz nominal).
- rst  in  1  synchronous reset, active-high.
- s_data  in  WIDTH  sample from filter engine.
- s_valid  in  1  s_data valid.
- s_ready  out  1  buffer can accept a sample; registered.
- dac_ack  in  1  1-cycle pull strobe from the DAC; the DAC latches dac_data on this edge.
- dac_data  out  WIDTH  registered sample presented to the DAC input.
- level  out  $clog2(DEPTH)+1  samples currently stored in the FIFO (dac_data register excluded).
- underrun  out  1  1-cycle pulse: dac_ack seen while the FIFO was empty.
- underrun_cnt  out  CNT_W  saturating count of underruns.
- clr_cnt  in  1  synchronous clear of underrun_cnt.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high (rst). No asynchronous paths.
- Reset values: all of the following are 0: dac_data, level, rd/wr pointers, underrun, underrun_cnt. s_ready is 1.
- Reset asserted mid-operation discards all buffered samples on that edge. Storage RAM contents need no reset.
- Push: a sample is written on any edge where s_valid && s_ready; it goes to mem[wr_ptr] and wr_ptr increments modulo DEPTH.
- s_ready = !(level == DEPTH), registered from next-state level. No combinational path from dac_ack to s_ready.
  - When full, a push is refused even if a pop occurs on the same edge.
- Pop: on an edge with dac_ack=1 and level>0, dac_data <= mem[rd_ptr] and rd_ptr increments modulo DEPTH.
  - The DAC has already latched the old dac_data on that same edge, so dac_data always holds the next sample to be consumed.
- Underrun: on an edge with dac_ack=1 and level==0:
  - dac_data is unchanged (hold last sample);
  - underrun=1 for the following cycle only;
  - underrun_cnt increments, saturating at all-ones.
- Simultaneous push and pop with 0<level<DEPTH: level is unchanged and both pointers advance.
- Push into an empty FIFO together with dac_ack on the same edge counts as an underrun. The pushed sample is stored (level becomes 1); there is no bypass.
- Latency: a sample pushed into an empty FIFO reaches dac_data on the first dac_ack edge after the push, and is consumed by the DAC on the following dac_ack.
- clr_cnt and an underrun on the same edge: clear wins, so underrun_cnt=0.
- Pointers are $clog2(DEPTH) bits and wrap naturally. level is tracked by an explicit up/down counter, not by pointer difference.
- dac_ack pulses closer than 1 cycle apart need no special handling; each pulse is one independent pop.

Optional Feature:
- Macro DAC_FEED_SOFTMUTE_EN.
- Defined: on each underrun edge, dac_data <= dac_data >>> 1 (arithmetic), except that a value of -1 becomes 0. Output decays to silence over at most WIDTH underruns instead of holding a DC level. Counting and the underrun pulse are unchanged.
- Undefined: hold behaviour as specified above.

Decomposition:
- Package speech256_dac_pkg: SAMPLE_W=16, DAC_PULL_PERIOD=256, and the typedef sample_t (signed logic [15:0]).
- One sub-module, dac_sample_fifo_mem: DEPTH x WIDTH register-file storage with write port (we, waddr, wdata) and asynchronous read (raddr, rdata).
- Pointers, level, underrun logic and the output register stay in the top level.

Test Plan:
- Reset then 3 pushes (0x1000, 0x2000, 0x3000), then 3 dac_ack pulses: dac_data becomes 0x1000, 0x2000, 0x3000 on successive acks; level goes 3→2→1→0; no underrun.
- Push 8 samples with no ack: s_ready drops to 0 after the 8th, a 9th s_valid is not accepted, level=8. One ack then restores s_ready next cycle.
- Empty FIFO with dac_data=0x7FF0, then 2 acks: dac_data stays 0x7FF0, two underrun pulses, underrun_cnt=2. With DAC_FEED_SOFTMUTE_EN: dac_data 0x3FF8 then 0x1FFC.
- level=4 with push and ack on the same edge: level stays 4, dac_data = oldest sample, wr/rd pointers each advance by 1.
- 300 underruns: underrun_cnt saturates at 0xFF. clr_cnt together with an underrun gives 0.
- rst asserted with level=5 mid-stream: next cycle level=0, dac_data=0, s_ready=1, underrun_cnt=0.

Source files
------------

// File: rtl/speech256_dac_pkg.sv
// Shared constants and types for the speech256 DAC output path.
package speech256_dac_pkg;

    localparam int SAMPLE_W        = 16;
    localparam int DAC_PULL_PERIOD = 256;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage : speech256_dac_pkg

// File: rtl/dac_sample_feeder_if.sv
// Valid/ready sample push channel from the filter engine into the DAC feeder.
interface dac_sample_feeder_if #(
    parameter int WIDTH = speech256_dac_pkg::SAMPLE_W
);

    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );

endinterface : dac_sample_feeder_if

// File: rtl/dac_sample_fifo_mem.sv
// DEPTH x WIDTH register-file storage: one write port, asynchronous read port.
module dac_sample_fifo_mem #(
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [WIDTH-1:0] word_q;
            logic [WIDTH-1:0] word_d;

            always_comb begin
                word_d = word_q;
                if (we && (waddr == ADDR_W'(gi))) begin
                    word_d = wdata;
                end
            end

            // Storage is deliberately left unreset; the pointers define validity.
            always_ff @(posedge clk) begin
                word_q <= word_d;
            end

            assign mem[gi] = word_q;
        end
    endgenerate

    assign rdata = mem[raddr];

endmodule : dac_sample_fifo_mem

// File: rtl/dac_sample_feeder.sv
// Elastic sample buffer feeding the sigma-delta DAC's pull interface.
// Optional DAC_FEED_SOFTMUTE_EN: halve the held sample on each underrun so the output decays to 0.
module dac_sample_feeder
    import speech256_dac_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = SAMPLE_W,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    dac_sample_feeder_if.slave      s_if,
    input  logic                    dac_ack,
    output logic [WIDTH-1:0]        dac_data,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    underrun,
    output logic [CNT_W-1:0]        underrun_cnt,
    input  logic                    clr_cnt
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LVL_W  = ADDR_W + 1;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              s_ready_q, s_ready_d;
    logic [WIDTH-1:0]  dac_data_q, dac_data_d;
    logic              underrun_q, underrun_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              push;
    logic              pop;
    logic              urun;
    logic [WIDTH-1:0]  rdata;

    dac_sample_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clk  (clk),
        .we   (push),
        .waddr(wr_ptr_q),
        .wdata(s_if.s_data),
        .raddr(rd_ptr_q),
        .rdata(rdata)
    );

    always_comb begin
        // Gate with the registered ready so a pop cannot open space for a push on the same edge.
        push       = s_if.s_valid && s_ready_q;
        pop        = dac_ack && (level_q != '0);
        urun       = dac_ack && (level_q == '0);

        wr_ptr_d   = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;

        level_d    = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        s_ready_d  = (level_d != LVL_W'(DEPTH));

        dac_data_d = dac_data_q;
        if (pop) begin
            dac_data_d = rdata;
        end else if (urun) begin
`ifdef DAC_FEED_SOFTMUTE_EN
            // -1 would stick at -1 under an arithmetic shift, so force it to silence.
            dac_data_d = (dac_data_q == '1) ? '0 : ($signed(dac_data_q) >>> 1);
`else
            dac_data_d = dac_data_q;
`endif
        end

        underrun_d = urun;

        cnt_d      = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (urun && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            s_ready_q  <= 1'b1;
            dac_data_q <= '0;
            underrun_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            s_ready_q  <= s_ready_d;
            dac_data_q <= dac_data_d;
            underrun_q <= underrun_d;
            cnt_q      <= cnt_d;
        end
    end

    assign s_if.s_ready = s_ready_q;
    assign dac_data     = dac_data_q;
    assign level        = level_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = cnt_q;

endmodule : dac_sample_feeder
